// File: rtl/calc_pkg.sv
// Shared encodings, widths, per-port state type and the calculator ALU
// for the four-port calc_responder.
package calc_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP2  = 2'd1,
        PEND = 2'd2
    } port_state_e;

    typedef struct packed {
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
    } alu_res_t;

    // Any error (carry, borrow, unknown command) reports zero data.
    function automatic alu_res_t calc_alu(input logic [CMD_W-1:0]  cmd,
                                          input logic [DATA_W-1:0] op1,
                                          input logic [DATA_W-1:0] op2);
        alu_res_t        res;
        logic [DATA_W:0] sum;
        res.resp = RESP_ERR;
        res.data = {DATA_W{1'b0}};
        sum      = {1'b0, op1} + {1'b0, op2};
        case (cmd)
            CMD_ADD: begin
                if (sum[DATA_W]) begin
                    res.resp = RESP_ERR;
                    res.data = {DATA_W{1'b0}};
                end else begin
                    res.resp = RESP_OK;
                    res.data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 > op1) begin
                    res.resp = RESP_ERR;
                    res.data = {DATA_W{1'b0}};
                end else begin
                    res.resp = RESP_OK;
                    res.data = op1 - op2;
                end
            end
            CMD_SHL: begin
                res.resp = RESP_OK;
                res.data = op1 << op2[4:0];
            end
            CMD_SHR: begin
                res.resp = RESP_OK;
                res.data = op1 >> op2[4:0];
            end
            default: begin
                res.resp = RESP_ERR;
                res.data = {DATA_W{1'b0}};
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/calc_responder_if.sv
// Per-port request/response bundle between four requesters and calc_responder.
interface calc_responder_if;
    import calc_pkg::*;

    logic [CMD_W-1:0]  req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
    logic [DATA_W-1:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic [1:0]        out_resp1,    out_resp2,    out_resp3,    out_resp4;
    logic [DATA_W-1:0] out_data1,    out_data2,    out_data3,    out_data4;

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4
    );

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4
    );

endinterface

// File: rtl/calc_port_fsm.sv
// One port's command sequencer: latches cmd/op1, then op2, then waits for
// an ALU grant. New commands are only accepted in IDLE.
module calc_port_fsm
    import calc_pkg::*;
(
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              grant,
    output logic              req,
    output logic [CMD_W-1:0]  cmd,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2
);

    port_state_e       state_r, state_s;
    logic [CMD_W-1:0]  cmd_r;
    logic [DATA_W-1:0] op1_r, op2_r;

    // State register
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latches: cmd/op1 on acceptance, op2 one cycle later
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            cmd_r <= CMD_NOP;
            op1_r <= {DATA_W{1'b0}};
            op2_r <= {DATA_W{1'b0}};
        end else if ((state_r == IDLE) && (cmd_in != CMD_NOP)) begin
            cmd_r <= cmd_in;
            op1_r <= data_in;
        end else if (state_r == OP2) begin
            op2_r <= data_in;
        end else begin
            cmd_r <= cmd_r;
            op1_r <= op1_r;
            op2_r <= op2_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_in != CMD_NOP) begin
                    state_s = OP2;
                end else begin
                    state_s = IDLE;
                end
            end
            OP2: state_s = PEND;
            PEND: begin
                if (grant) begin
                    state_s = IDLE;
                end else begin
                    state_s = PEND;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign req = (state_r == PEND);
    assign cmd = cmd_r;
    assign op1 = op1_r;
    assign op2 = op2_r;

endmodule

// File: rtl/calc_responder.sv
// Four-port calculator: per-port sequencers share one ALU through a
// round-robin arbiter; results are registered for a single cycle.
module calc_responder
    import calc_pkg::*;
(
    input  logic             c_clk,
    input  logic             reset,
    calc_responder_if.slave  bus
);

    logic [CMD_W-1:0]  cmd_in_s [4];
    logic [DATA_W-1:0] data_in_s[4];
    logic [CMD_W-1:0]  cmd_s    [4];
    logic [DATA_W-1:0] op1_s    [4];
    logic [DATA_W-1:0] op2_s    [4];
    logic [3:0]        req_s, grant_s;
    logic [1:0]        ptr_r, gidx_s;
    logic              any_grant_s;
    alu_res_t          alu_s;
    logic [1:0]        resp_r[4];
    logic [DATA_W-1:0] data_r[4];

    assign cmd_in_s[0]  = bus.req1_cmd_in;
    assign cmd_in_s[1]  = bus.req2_cmd_in;
    assign cmd_in_s[2]  = bus.req3_cmd_in;
    assign cmd_in_s[3]  = bus.req4_cmd_in;
    assign data_in_s[0] = bus.req1_data_in;
    assign data_in_s[1] = bus.req2_data_in;
    assign data_in_s[2] = bus.req3_data_in;
    assign data_in_s[3] = bus.req4_data_in;

    for (genvar g = 0; g < 4; g++) begin : g_port
        calc_port_fsm u_port (
            .c_clk   (c_clk),
            .reset   (reset),
            .cmd_in  (cmd_in_s[g]),
            .data_in (data_in_s[g]),
            .grant   (grant_s[g]),
            .req     (req_s[g]),
            .cmd     (cmd_s[g]),
            .op1     (op1_s[g]),
            .op2     (op2_s[g])
        );
    end

    // Round-robin pick, searching from the port after the last winner
    always_comb begin
        logic [1:0] idx;
        grant_s     = 4'b0000;
        gidx_s      = 2'd0;
        any_grant_s = 1'b0;
        idx         = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_r + 2'(i);
            if (!any_grant_s && req_s[idx]) begin
                grant_s[idx] = 1'b1;
                gidx_s       = idx;
                any_grant_s  = 1'b1;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    assign alu_s = calc_alu(cmd_s[gidx_s], op1_s[gidx_s], op2_s[gidx_s]);

    // Pointer reset to port 4 so the first search begins at port 1
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= 2'd3;
        end else if (any_grant_s) begin
            ptr_r <= gidx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Response registers: only the granted port sees a non-zero result
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 4; p++) begin
                resp_r[p] <= RESP_NONE;
                data_r[p] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (grant_s[p]) begin
                    resp_r[p] <= alu_s.resp;
                    data_r[p] <= alu_s.data;
                end else begin
                    resp_r[p] <= RESP_NONE;
                    data_r[p] <= {DATA_W{1'b0}};
                end
            end
        end
    end

    assign bus.out_resp1 = resp_r[0];
    assign bus.out_resp2 = resp_r[1];
    assign bus.out_resp3 = resp_r[2];
    assign bus.out_resp4 = resp_r[3];
    assign bus.out_data1 = data_r[0];
    assign bus.out_data2 = data_r[1];
    assign bus.out_data3 = data_r[2];
    assign bus.out_data4 = data_r[3];

endmodule

// File: tb/tb_calc_responder.sv
// Directed self-checking bench for calc_responder.
module tb_calc_responder;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    calc_responder_if bus ();

    calc_responder dut (
        .c_clk (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
        case (p)
            0: begin bus.req1_cmd_in = c; bus.req1_data_in = d; end
            1: begin bus.req2_cmd_in = c; bus.req2_data_in = d; end
            2: begin bus.req3_cmd_in = c; bus.req3_data_in = d; end
            3: begin bus.req4_cmd_in = c; bus.req4_data_in = d; end
            default: ;
        endcase
    endtask

    function automatic logic [33:0] get_out(input int p);
        case (p)
            0: return {bus.out_resp1, bus.out_data1};
            1: return {bus.out_resp2, bus.out_data2};
            2: return {bus.out_resp3, bus.out_data3};
            default: return {bus.out_resp4, bus.out_data4};
        endcase
    endfunction

    // Port p (0..3, or -1 for none) must show r/d; all other ports 0/0.
    task automatic chk_ports(input string tag, input int p, input logic [1:0] r, input logic [31:0] d);
        logic [33:0] obs;
        logic [33:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            obs   = get_out(i);
            exp_v = (i == p) ? {r, d} : 34'd0;
            n_assert++;
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s port%0d: observed resp=%0d data=%h, expected resp=%0d data=%h",
                       tag, i + 1, obs[33:32], obs[31:0], exp_v[33:32], exp_v[31:0]);
            end
        end
    endtask

    task automatic issue_one(input string tag, input int p, input logic [3:0] c,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] er, input logic [31:0] ed);
        set_port(p, c, a);
        step();
        set_port(p, 4'd0, b);
        step();
        set_port(p, 4'd0, 32'd0);
        chk_ports({tag, "_pend"}, -1, 2'd0, 32'd0);
        step();
        chk_ports(tag, p, er, ed);
        step();
        chk_ports({tag, "_after"}, -1, 2'd0, 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        for (int i = 0; i < 4; i++) set_port(i, 4'd0, 32'd0);
        #1;
        chk_ports("reset_state", -1, 2'd0, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        issue_one("p1_add", 0, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);
        issue_one("p2_add_ovf", 1, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0);
        issue_one("p2_sub_neg", 1, 4'd2, 32'd3, 32'd5, 2'd2, 32'd0);
        issue_one("p2_sub_ok", 1, 4'd2, 32'd5, 32'd3, 2'd1, 32'd2);
        issue_one("p3_shl", 2, 4'd5, 32'd1, 32'h21, 2'd1, 32'd2);
        issue_one("p3_shr", 2, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1);
        issue_one("p3_inv", 2, 4'd3, 32'h1234, 32'h5678, 2'd2, 32'd0);

        // Port 4: cmd held high through OP2 and PEND must be ignored
        set_port(3, 4'd1, 32'd10);
        step();
        set_port(3, 4'd1, 32'd20);
        step();
        set_port(3, 4'd1, 32'd99);
        chk_ports("p4_ign_pend", -1, 2'd0, 32'd0);
        step();
        set_port(3, 4'd0, 32'd0);
        chk_ports("p4_ign_resp", 3, 2'd1, 32'd30);
        step();
        chk_ports("p4_ign_after1", -1, 2'd0, 32'd0);
        step();
        chk_ports("p4_ign_after2", -1, 2'd0, 32'd0);

        // Two bursts: all ports ADD n+n together, served 1,2,3,4 each time
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) set_port(i, 4'd1, 32'(i + 1));
            step();
            for (int i = 0; i < 4; i++) set_port(i, 4'd0, 32'(i + 1));
            step();
            for (int i = 0; i < 4; i++) set_port(i, 4'd0, 32'd0);
            chk_ports($sformatf("burst%0d_pend", b), -1, 2'd0, 32'd0);
            for (int k = 0; k < 4; k++) begin
                step();
                chk_ports($sformatf("burst%0d_p%0d", b, k + 1), k, 2'd1, 32'(2 * (k + 1)));
            end
            step();
            chk_ports($sformatf("burst%0d_after", b), -1, 2'd0, 32'd0);
        end

        // Reset during port 1's op2 cycle while port 2's response is visible
        set_port(1, 4'd1, 32'd1);
        step();
        set_port(1, 4'd0, 32'd1);
        step();
        set_port(1, 4'd0, 32'd0);
        set_port(0, 4'd1, 32'd7);
        step();
        set_port(0, 4'd0, 32'd8);
        chk_ports("rst_pre", 1, 2'd1, 32'd2);
        reset = 1'b0;
        #1;
        chk_ports("rst_async", -1, 2'd0, 32'd0);
        step();
        set_port(0, 4'd0, 32'd0);
        chk_ports("rst_hold", -1, 2'd0, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_ports($sformatf("rst_discard%0d", k), -1, 2'd0, 32'd0);
        end
        issue_one("rst_fresh", 0, 4'd1, 32'd4, 32'd4, 2'd1, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_responder.md
# calc_responder

Four-port 32-bit calculator that answers the request/response protocol the port checker monitors. Each port issues a command plus two operands over two cycles and receives a one-cycle response code with result data. A single shared ALU is time-shared among the ports by round-robin arbitration. This is the responding end of the per-port `reqN_cmd_in`/`reqN_data_in` → `out_respN`/`out_dataN` interface.

## Interface
- `DATA_W`, 32: operand and result width.
- `CMD_W`, 4: command field width.
- `c_clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req1_cmd_in` … `req4_cmd_in`  in  CMD_W  per-port command; 0 means no command.
- `req1_data_in` … `req4_data_in`  in  DATA_W  per-port operand bus.
- `out_resp1` … `out_resp4`  out  2  per-port response: 0 none, 1 success, 2 overflow/underflow/invalid command, 3 never driven.
- `out_data1` … `out_data4`  out  DATA_W  per-port result, valid only while the matching `out_respN` is non-zero.

## Operation
- Commands: 1 ADD, 2 SUB, 5 SHL, 6 SHR. Any other non-zero value is an invalid command.
- Each port runs its own FSM:
  - IDLE: a non-zero cmd latches cmd and op1 (`data_in` of the same cycle), then goes to OP2.
  - OP2: latches op2 from `data_in` unconditionally, then goes to PEND. `cmd_in` is ignored in this cycle.
  - PEND: requests the ALU. On grant, goes to IDLE at the end of the grant cycle. `cmd_in` is ignored while in OP2 or PEND, with no error response.
- Arbiter:
  - Round-robin over ports in PEND; at most one grant per cycle.
  - The search starts at the port after the last granted one.
  - After reset the pointer selects port 1 first.
- ALU, combinational, on the granted port's latched operands:
  - ADD: 33-bit sum. If the carry is set → resp 2, data 0. Otherwise resp 1, data = sum[31:0].
  - SUB: if op2 > op1 (unsigned) → resp 2, data 0. Otherwise resp 1, data = op1 − op2.
  - SHL/SHR: logical shift by op2[4:0]; op2[31:5] is ignored. Always resp 1.
  - Invalid command: resp 2, data 0. It still consumes the op2 cycle and arbitration.
- The result is registered into the granted port's `out_respN`/`out_dataN`. All other ports output 0/0 that cycle.

## Timing
- Reset, asynchronous: all FSMs go to IDLE, latched operands clear, the RR pointer resets, and all `out_respN`/`out_dataN` are 0. Reset asserted mid-operation discards every in-flight command; no response is ever produced for it.
- Command in cycle T−1, op2 in cycle T, PEND in T+1.
- Minimum latency: response visible in cycle T+2 when the port is granted in T+1. Each cycle of lost arbitration adds one cycle.
- A response lasts exactly one cycle; outputs return to 0/0 the next cycle unless a new grant for that port lands.
- A port is IDLE in the response cycle, so a new cmd may be presented in T+2. Minimum issue spacing is 3 cycles per port.
- Simultaneous events:
  - All four ports entering PEND in the same cycle are served in consecutive cycles in RR order. The worst-case wait is 3 extra cycles.
  - A port entering PEND the same cycle another is granted joins the next arbitration.

## Structure
- Package `calc_pkg` holds:
  - Command encodings: `CMD_NOP`, `CMD_ADD`, `CMD_SUB`, `CMD_SHL`, `CMD_SHR`.
  - Response encodings: `RESP_NONE`, `RESP_OK`, `RESP_ERR`.
  - FSM state enum: IDLE, OP2, PEND.
  - `DATA_W`/`CMD_W` defaults.
- Sub-module `calc_port_fsm` is instantiated 4×. It holds the per-port FSM, operand/cmd latches, and the PEND request/grant.
- Arbiter, ALU and output registers live in the top level.

## Test plan
- Port 1: cmd 1, data 2 at T−1; data 3 at T → `out_resp1`=1, `out_data1`=5 in T+2 only; other ports 0/0.
- Port 2: ADD 0xFFFFFFFF + 1 → resp 2, data 0. Port 2: SUB 3 − 5 → resp 2, data 0. SUB 5 − 3 → resp 1, data 2.
- Port 3: SHL 1 by 0x21 → resp 1, data 2 (only the low 5 bits of op2 are used). SHR 0x80000000 by 31 → resp 1, data 1. Cmd 3 with any operands → resp 2, data 0.
- All four ports issue ADD n+n (n = port number) in the same cycle. Responses arrive at ports 1, 2, 3, 4 in cycles T+2..T+5 with data 2, 4, 6, 8. A repeat burst starts from port 1 again, because the pointer is now past port 4.
- Port 4: cmd 1 while in OP2/PEND → ignored; exactly one response, for the original command.
- `reset` driven low in cycle T (op2 cycle) → all outputs 0 immediately. After release, no response appears for the discarded command, and a fresh command completes normally with latency T+2.
